// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes, operand width, default settle latencies and issue FSM states
package alu_pkg;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_MUL = 2'b10;
  localparam logic [1:0] ALU_DIV = 2'b11;
  localparam int ALU_WIDTH = 16;
  localparam int ADDSUB_CYCLES = 1;
  localparam int MULDIV_CYCLES = 20;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} issue_state_t;
endpackage

// File: rtl/alu_wait_timer.sv
// alu_wait_timer: loadable down-counter with enable; stops at zero and flags it
module alu_wait_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         en,
  output logic         zero
);
  logic [W-1:0] count;
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (load) count <= value;
    else if (en && !zero) count <= count - 1'b1;
  assign zero = count == '0;
endmodule

// File: rtl/alu_issue_unit.sv
// alu_issue_unit: issues one op at a time to the multi-cycle ALU, waits its settle time, holds the response.
// Optional macro ALU_ISSUE_DIV0_TRAP_EN: DIV by zero answers immediately and flags rsp_div0.
module alu_issue_unit #(
  parameter int WIDTH = alu_pkg::ALU_WIDTH,
  parameter int ADDSUB_CYCLES = alu_pkg::ADDSUB_CYCLES,
  parameter int MULDIV_CYCLES = alu_pkg::MULDIV_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero,
`ifdef ALU_ISSUE_DIV0_TRAP_EN
  output logic             rsp_div0,
`endif
  output logic             busy
);
  import alu_pkg::*;
  // zero cycle counts are clamped to one
  localparam int AS = ADDSUB_CYCLES < 1 ? 1 : ADDSUB_CYCLES;
  localparam int MD = MULDIV_CYCLES < 1 ? 1 : MULDIV_CYCLES;
  localparam int CW = $clog2((AS > MD ? AS : MD) + 1);
  issue_state_t state, next;
  logic hs, div0, trap, cap, t_zero;
  assign req_ready = state == IDLE;
  assign busy = state != IDLE;
  assign rsp_valid = state == RESP;
  assign hs = req_valid && req_ready;
`ifdef ALU_ISSUE_DIV0_TRAP_EN
  assign div0 = req_op == ALU_DIV && req_b == '0;
`else
  assign div0 = 1'b0;
`endif
  assign trap = hs && div0;
  assign cap = state == WAIT && t_zero;
  alu_wait_timer #(.W(CW)) u_timer (
    .clk(clk),
    .rst(rst),
    .load(hs),
    .value(req_op[1] ? CW'(MD - 1) : CW'(AS - 1)),
    .en(state == WAIT),
    .zero(t_zero)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    if (hs) next = div0 ? RESP : WAIT;
    if (cap) next = RESP;
    if (state == RESP && rsp_ready) next = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      alu_a <= '0;
      alu_b <= '0;
      alu_op <= ALU_ADD;
      rsp_result <= '0;
      rsp_carry <= 1'b0;
      rsp_zero <= 1'b0;
    end else begin
      if (hs) begin
        alu_a <= req_a;
        alu_b <= req_b;
        alu_op <= req_op;
      end
      if (cap || trap) begin
        rsp_result <= trap ? '0 : alu_result;
        rsp_carry <= !trap && alu_carry;
        rsp_zero <= trap || alu_zero;
      end
    end
`ifdef ALU_ISSUE_DIV0_TRAP_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) rsp_div0 <= 1'b0;
    else if (cap || trap) rsp_div0 <= trap;
`endif
endmodule

// File: tb/tb_alu_issue_unit.sv
// tb_alu_issue_unit: random and directed requests against a behavioural ALU, checked by a scoreboard monitor.
// Honours ALU_ISSUE_DIV0_TRAP_EN when the DUT is built with it.
module tb_alu_issue_unit;
  localparam int W = 16, AS = 1, MD = 20;
  logic clk = 0, rst = 1, req_valid = 0, rsp_ready = 0;
  logic [1:0] req_op = '0;
  logic [W-1:0] req_a = '0, req_b = '0;
  logic req_ready, rsp_valid, rsp_carry, rsp_zero, busy, alu_carry, alu_zero;
  logic [1:0] alu_op;
  logic [W-1:0] alu_a, alu_b, alu_result, rsp_result;
`ifdef ALU_ISSUE_DIV0_TRAP_EN
  logic rsp_div0;
`endif
  int n_chk = 0, n_fail = 0, cyc = 0, age = 0, mode = 0;
  bit seen = 0;
  typedef struct {
    logic [W-1:0] a, b, res;
    logic [1:0] op;
    logic c, z, d0;
    int due;
  } exp_t;
  exp_t sb[$];

  alu_issue_unit #(.WIDTH(W), .ADDSUB_CYCLES(AS), .MULDIV_CYCLES(MD)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
`ifdef ALU_ISSUE_DIV0_TRAP_EN
    .rsp_div0(rsp_div0),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU behaviour: {carry, result}; DIV truncates toward zero, DIV by zero gives an arbitrary marker
  function automatic logic [W:0] ref_alu(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] p;
    case (op)
      2'b00: return {1'b0, a} + {1'b0, b};
      2'b01: return {1'b0, a} - {1'b0, b};
      2'b10: begin p = $signed(a) * $signed(b); return {1'b0, p[W-1:0]}; end
      default: return {1'b0, b == '0 ? 16'hDEAD : W'($signed(a) / $signed(b))};
    endcase
  endfunction

  // the modelled ALU presents garbage until its settle time has elapsed since operands were issued
  always @(posedge clk) age <= (req_valid && req_ready) ? 0 : age + 1;
  always_comb begin
    {alu_carry, alu_result} = ref_alu(alu_op, alu_a, alu_b);
    if (age < (alu_op[1] ? MD : AS) - 1) alu_result = alu_result ^ 16'hA5A5;
    alu_zero = alu_result == '0;
  end

  always begin
    @(posedge clk);
    #1 rsp_ready = mode == 1 ? 1'b1 : mode == 2 ? 1'b0 : $urandom_range(0, 3) != 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  initial begin
    exp_t e;
    logic [W:0] r;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (sb.size() == 0) chk("spurious_rsp", 32'(rsp_valid), 0);
        else begin
          chk("busy", 32'(busy), 1);
          chk("req_ready_low", 32'(req_ready), 0);
          if (!sb[0].d0) begin
            chk("alu_a_hold", 32'(alu_a), 32'(sb[0].a));
            chk("alu_b_hold", 32'(alu_b), 32'(sb[0].b));
            chk("alu_op_hold", 32'(alu_op), 32'(sb[0].op));
          end
          if (rsp_valid) begin
            if (!seen) begin chk("latency", cyc, sb[0].due); seen = 1; end
            chk("rsp_result", 32'(rsp_result), 32'(sb[0].res));
            chk("rsp_carry", 32'(rsp_carry), 32'(sb[0].c));
            chk("rsp_zero", 32'(rsp_zero), 32'(sb[0].z));
`ifdef ALU_ISSUE_DIV0_TRAP_EN
            chk("rsp_div0", 32'(rsp_div0), 32'(sb[0].d0));
`endif
            if (rsp_ready) begin void'(sb.pop_front()); seen = 0; end
          end else if (cyc >= sb[0].due) begin
            chk("rsp_valid_by_due", 32'(rsp_valid), 1);
            void'(sb.pop_front());
          end
        end
        if (req_valid && req_ready) begin
          r = ref_alu(req_op, req_a, req_b);
          e.a = req_a; e.b = req_b; e.op = req_op;
          e.res = r[W-1:0]; e.c = r[W]; e.z = r[W-1:0] == '0; e.d0 = 1'b0;
          e.due = cyc + 1 + (req_op[1] ? MD : AS);
`ifdef ALU_ISSUE_DIV0_TRAP_EN
          if (req_op == 2'b11 && req_b == '0) begin
            e.res = '0; e.c = 1'b0; e.z = 1'b1; e.d0 = 1'b1; e.due = cyc + 1;
          end
`endif
          sb.push_back(e);
        end
      end
    end
  end

  task automatic reset_pulse();
    @(posedge clk);
    #1 rst = 1; req_valid = 0; sb.delete(); seen = 0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_alu_op", 32'(alu_op), 0);
    chk("rst_alu_a", 32'(alu_a), 0);
    chk("rst_alu_b", 32'(alu_b), 0);
    chk("rst_rsp_result", 32'(rsp_result), 0);
    chk("rst_rsp_flags", 32'({rsp_carry, rsp_zero}), 0);
`ifdef ALU_ISSUE_DIV0_TRAP_EN
    chk("rst_rsp_div0", 32'(rsp_div0), 0);
`endif
    @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid = 1; req_op = op; req_a = a; req_b = b;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    if (!req_ready) chk("req_accept", 32'(req_ready), 1);
    @(posedge clk);
    #1 req_valid = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 500 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) chk("drain", 32'(sb.size()), 0);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    reset_pulse();
    mode = 1;
    issue(2'b00, 16'd100, 16'hFFE2);
    wait_idle();
    issue(2'b10, 16'd300, 16'd300);
    wait_idle();
    mode = 2;
    issue(2'b01, 16'd5, 16'd5);
    req_valid = 1; req_op = 2'b00; req_a = 16'd1; req_b = 16'd2;
    repeat (12) @(posedge clk);
    #1 mode = 1;
    issue(2'b00, 16'd1, 16'd2);
    wait_idle();
    issue(2'b11, 16'hFFF9, 16'd2);
    repeat (9) @(posedge clk);
    reset_pulse();
    issue(2'b11, 16'hFFF9, 16'd2);
    wait_idle();
    issue(2'b11, 16'd1234, 16'd0);
    wait_idle();
    mode = 0;
    repeat (40) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
      issue(2'($urandom), 16'($urandom), $urandom_range(0, 4) == 0 ? 16'd0 : 16'($urandom));
    end
    wait_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish by cycle %0d", cyc);
    $fatal(1);
  end
endmodule
